// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer driving a byte-wide, big-endian
// data memory one byte per cycle. Optional feature macro: MISALIGN_TRAP_EN
// (misaligned accesses complete immediately with resp_err instead of running).
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              req_write,
    input  logic [1:0]        req_read,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    // Access type: 0 store, 1 word load, 2 signed half load, 3 unsigned half load
    logic [1:0]        rtype_q, rtype_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       lbuf_q, lbuf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        cur_byte;
    logic [1:0]        last_idx;
    logic              is_store;

`ifdef MISALIGN_TRAP_EN
    logic err_q, err_d;
    logic misalign;

    // Word accesses need addr[1:0]==0, halfword loads need addr[0]==0.
    always_comb begin
        misalign = 1'b0;
        if (req_write || req_read == 2'd1) begin
            misalign = (req_addr[1:0] != 2'b00);
        end else if (req_read[1]) begin
            misalign = req_addr[0];
        end
    end
`endif

    // Per-byte address/data selection for the current transfer beat.
    always_comb begin
        is_store = (rtype_q == 2'd0);
        last_idx = rtype_q[1] ? 2'd1 : 2'd3;
        cur_addr = addr_q + ADDR_W'(idx_q);
        unique case (idx_q)
            2'd0:    cur_byte = wdata_q[31:24];
            2'd1:    cur_byte = wdata_q[23:16];
            2'd2:    cur_byte = wdata_q[15:8];
            default: cur_byte = wdata_q[7:0];
        endcase
    end

    // Next-state logic: accept, byte sequencing, load assembly, response capture.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rtype_d     = rtype_q;
        idx_d       = idx_q;
        lbuf_d      = lbuf_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MISALIGN_TRAP_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                // A request with neither write nor read is consumed as a no-op.
                if (req_valid && (req_write || req_read != 2'd0)) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rtype_d = req_write ? 2'd0 : req_read;
                    idx_d   = 2'd0;
                    state_d = StXfer;
`ifdef MISALIGN_TRAP_EN
                    if (misalign) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
`endif
                end
            end
            StXfer: begin
                mem_addr_d = cur_addr;
                if (is_store) begin
                    mem_wdata_d = cur_byte;
                end else begin
                    unique case (idx_q)
                        2'd0:    lbuf_d[31:24] = mem_rdata;
                        2'd1:    lbuf_d[23:16] = mem_rdata;
                        2'd2:    lbuf_d[15:8]  = mem_rdata;
                        default: lbuf_d[7:0]   = mem_rdata;
                    endcase
                end
                if (idx_q == last_idx) begin
                    unique case (rtype_q)
                        2'd0:    rdata_d = 32'h0;
                        2'd1:    rdata_d = lbuf_d;
                        2'd2:    rdata_d = {{16{lbuf_d[31]}}, lbuf_d[31:16]};
                        default: rdata_d = {16'h0, lbuf_d[31:16]};
                    endcase
`ifdef MISALIGN_TRAP_EN
                    err_d = 1'b0;
`endif
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; async reset aborts any access and drops mem_we at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rtype_q     <= 2'd0;
            idx_q       <= 2'd0;
            lbuf_q      <= 32'h0;
            rdata_q     <= 32'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h0;
`ifdef MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rtype_q     <= rtype_d;
            idx_q       <= idx_d;
            lbuf_q      <= lbuf_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MISALIGN_TRAP_EN
            err_q       <= err_d;
`endif
        end
    end

    // Outputs; the memory bus holds its last value outside XFER.
    always_comb begin
        req_ready  = (state_q == StIdle);
        stall      = !req_ready;
        resp_valid = (state_q == StDone);
        resp_rdata = rdata_q;
        mem_we     = (state_q == StXfer) && is_store;
        mem_addr   = (state_q == StXfer) ? cur_addr : mem_addr_q;
        mem_wdata  = mem_we ? cur_byte : mem_wdata_q;
`ifdef MISALIGN_TRAP_EN
        resp_err   = err_q;
`else
        resp_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte-wide memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic [1:0]  req_read;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Sparse memory: the addresses used here map to distinct slots.
    logic [7:0]  mem [64];
    logic        poke_en;
    logic [31:0] poke_addr;
    logic [7:0]  poke_data;

    function automatic logic [5:0] slot(input logic [31:0] a);
        return {a[9:8], a[3:0]};
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (poke_en) mem[slot(poke_addr)] <= poke_data;
        else if (mem_we) mem[slot(mem_addr)] <= mem_wdata;
    end

    assign mem_rdata = mem[slot(mem_addr)];

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_write  (req_write),
        .req_read   (req_read),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Present a request in an idle cycle; returns just after the accept edge.
    task automatic start_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                             input logic wr, input logic [1:0] rd);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wdata = wd; req_write = wr; req_read = rd;
        #1;
        check_eq({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        check_eq({tag, ".idle_valid"}, {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0; req_read = 2'd0;
    endtask

    // One XFER cycle: bus contents and stall.
    task automatic bus_cycle(input string tag, input logic we, input logic [31:0] a,
                             input logic [7:0] wd);
        @(negedge clk);
        check_eq({tag, ".stall"}, {31'h0, stall}, 32'h1);
        check_eq({tag, ".valid"}, {31'h0, resp_valid}, 32'h0);
        check_eq({tag, ".we"}, {31'h0, mem_we}, {31'h0, we});
        check_eq({tag, ".addr"}, mem_addr, a);
        if (we) check_eq({tag, ".wdata"}, {24'h0, mem_wdata}, {24'h0, wd});
    endtask

    task automatic done_cycle(input string tag, input logic [31:0] rdata, input logic err);
        @(negedge clk);
        check_eq({tag, ".valid"}, {31'h0, resp_valid}, 32'h1);
        check_eq({tag, ".rdata"}, resp_rdata, rdata);
        check_eq({tag, ".err"}, {31'h0, resp_err}, {31'h0, err});
        check_eq({tag, ".we"}, {31'h0, mem_we}, 32'h0);
        check_eq({tag, ".stall"}, {31'h0, stall}, 32'h1);
    endtask

    function automatic logic [31:0] peek(input logic [31:0] a);
        return {24'h0, mem[slot(a)]};
    endfunction

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        req_write = 1'b0; req_read = 2'd0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;

        poke(32'h200, 8'hDE); poke(32'h201, 8'hAD); poke(32'h202, 8'hBE); poke(32'h203, 8'hEF);
        poke(32'h300, 8'h80); poke(32'h301, 8'h01);
        poke(32'hFFFF_FFFE, 8'h12); poke(32'hFFFF_FFFF, 8'h34);
        poke(32'h0, 8'h56); poke(32'h1, 8'h78);

        @(negedge clk);
        check_eq("rst.ready", {31'h0, req_ready}, 32'h1);
        check_eq("rst.stall", {31'h0, stall}, 32'h0);
        check_eq("rst.valid", {31'h0, resp_valid}, 32'h0);
        check_eq("rst.rdata", resp_rdata, 32'h0);
        check_eq("rst.err", {31'h0, resp_err}, 32'h0);
        check_eq("rst.we", {31'h0, mem_we}, 32'h0);
        check_eq("rst.addr", mem_addr, 32'h0);
        check_eq("rst.wdata", {24'h0, mem_wdata}, 32'h0);
        rst_n = 1'b1;

        // Word store, MSB first.
        start_req("st", 32'h100, 32'h1122_3344, 1'b1, 2'd0);
        bus_cycle("st.b0", 1'b1, 32'h100, 8'h11);
        bus_cycle("st.b1", 1'b1, 32'h101, 8'h22);
        bus_cycle("st.b2", 1'b1, 32'h102, 8'h33);
        bus_cycle("st.b3", 1'b1, 32'h103, 8'h44);
        done_cycle("st.done", 32'h0, 1'b0);
        check_eq("st.m100", peek(32'h100), 32'h11);
        check_eq("st.m103", peek(32'h103), 32'h44);

        // Word load, issued back-to-back.
        start_req("ldw", 32'h200, 32'h0, 1'b0, 2'd1);
        for (int k = 0; k < 4; k++) bus_cycle("ldw.b", 1'b0, 32'h200 + k, 8'h0);
        done_cycle("ldw.done", 32'hDEAD_BEEF, 1'b0);

        // Halfword loads, signed then unsigned.
        start_req("lhs", 32'h300, 32'h0, 1'b0, 2'd2);
        bus_cycle("lhs.b0", 1'b0, 32'h300, 8'h0);
        bus_cycle("lhs.b1", 1'b0, 32'h301, 8'h0);
        done_cycle("lhs.done", 32'hFFFF_8001, 1'b0);
        start_req("lhu", 32'h300, 32'h0, 1'b0, 2'd3);
        bus_cycle("lhu.b0", 1'b0, 32'h300, 8'h0);
        bus_cycle("lhu.b1", 1'b0, 32'h301, 8'h0);
        done_cycle("lhu.done", 32'h0000_8001, 1'b0);
        @(negedge clk);
        check_eq("lhu.hold", resp_rdata, 32'h0000_8001);

        // No-op request: accepted, no response, bus idle.
        start_req("nop", 32'h100, 32'hFFFF_FFFF, 1'b0, 2'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("nop.ready", {31'h0, req_ready}, 32'h1);
            check_eq("nop.valid", {31'h0, resp_valid}, 32'h0);
            check_eq("nop.we", {31'h0, mem_we}, 32'h0);
        end

        // Misaligned word store.
        start_req("mis", 32'h102, 32'h5566_7788, 1'b1, 2'd0);
`ifdef MISALIGN_TRAP_EN
        done_cycle("mis.trap", 32'h0, 1'b1);
        check_eq("mis.m102", peek(32'h102), 32'h33);
        check_eq("mis.m103", peek(32'h103), 32'h44);
`else
        bus_cycle("mis.b0", 1'b1, 32'h102, 8'h55);
        bus_cycle("mis.b1", 1'b1, 32'h103, 8'h66);
        bus_cycle("mis.b2", 1'b1, 32'h104, 8'h77);
        bus_cycle("mis.b3", 1'b1, 32'h105, 8'h88);
        done_cycle("mis.done", 32'h0, 1'b0);
        check_eq("mis.m102", peek(32'h102), 32'h55);
        check_eq("mis.m105", peek(32'h105), 32'h88);
`endif

        // Word load across the top of the address space.
        start_req("wrap", 32'hFFFF_FFFE, 32'h0, 1'b0, 2'd1);
`ifdef MISALIGN_TRAP_EN
        done_cycle("wrap.trap", 32'h0, 1'b1);
`else
        bus_cycle("wrap.b0", 1'b0, 32'hFFFF_FFFE, 8'h0);
        bus_cycle("wrap.b1", 1'b0, 32'hFFFF_FFFF, 8'h0);
        bus_cycle("wrap.b2", 1'b0, 32'h0000_0000, 8'h0);
        bus_cycle("wrap.b3", 1'b0, 32'h0000_0001, 8'h0);
        done_cycle("wrap.done", 32'h1234_5678, 1'b0);
`endif

        // Reset after the second byte of a store aborts the access.
        start_req("abt", 32'h108, 32'hAABB_CCDD, 1'b1, 2'd0);
        bus_cycle("abt.b0", 1'b1, 32'h108, 8'hAA);
        bus_cycle("abt.b1", 1'b1, 32'h109, 8'hBB);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abt.we", {31'h0, mem_we}, 32'h0);
        check_eq("abt.valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check_eq("abt.valid2", {31'h0, resp_valid}, 32'h0);
        rst_n = 1'b1;
        check_eq("abt.m108", peek(32'h108), 32'hAA);
        check_eq("abt.m109", peek(32'h109), 32'hBB);
        check_eq("abt.m10a", peek(32'h10A), 32'h00);
        check_eq("abt.m10b", peek(32'h10B), 32'h00);
        start_req("rel", 32'h200, 32'h0, 1'b0, 2'd1);
        for (int k = 0; k < 4; k++) bus_cycle("rel.b", 1'b0, 32'h200 + k, 8'h0);
        done_cycle("rel.done", 32'hDEAD_BEEF, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
